// File: rtl/mxv_feeder.sv
// Operand store and skewed stream sequencer feeding an N-PE
// matrix-vector chain; all outputs are registered.
module mxv_feeder #(
    parameter int N           = 4,
    parameter int Word_Length = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic                       wr_sel,
    input  logic [$clog2(N*N)-1:0]     wr_addr,
    input  logic [Word_Length-1:0]     wr_data,
    input  logic                       go,
    output logic                       pe_start,
    output logic [Word_Length-1:0]     pe_v,
    output logic [N*Word_Length-1:0]   pe_a,
    output logic                       busy,
    output logic                       done,
    output logic                       load_err
);

    localparam int AW  = $clog2(N*N);
    localparam int AW1 = AW + 1;
    localparam int VW  = $clog2(N);
    localparam int KW  = $clog2(2*N);
    localparam int W   = Word_Length;

    localparam logic [AW:0]   VLIM  = AW1'(N);
    localparam logic [AW:0]   MLIM  = AW1'(N*N);
    localparam logic [KW-1:0] KN    = KW'(N);
    localparam logic [KW-1:0] KLAST = KW'(2*N-2);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t          state, state_nx;
    logic [KW-1:0]   k, k_nx;
    logic [W-1:0]    mat [N*N];
    logic [W-1:0]    vec [N];

    logic            addr_ok;
    logic            wr_ok;
    logic            wr_bad;

    logic            start_d;
    logic            busy_d;
    logic            done_d;
    logic [W-1:0]    v_d;
    logic [N*W-1:0]  a_d;

    // Writes land only while idle so a stream sees the go-edge operands
    always_comb begin
        addr_ok = wr_sel ? ({1'b0, wr_addr} < VLIM)
                         : ({1'b0, wr_addr} < MLIM);
        wr_ok   = wr_en && (state == IDLE) && addr_ok;
        wr_bad  = wr_en && !wr_ok;
    end

    // Operand store, cleared by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N*N; i++) mat[i] <= '0;
            for (int i = 0; i < N; i++)   vec[i] <= '0;
        end else if (wr_ok) begin
            if (wr_sel) vec[wr_addr[VW-1:0]] <= wr_data;
            else        mat[wr_addr]         <= wr_data;
        end
    end

    // State and step counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            k     <= '0;
        end else begin
            state <= state_nx;
            k     <= k_nx;
        end
    end

    // Next-state logic; go outside IDLE is simply not looked at
    always_comb begin
        state_nx = state;
        k_nx     = k;
        unique case (state)
            IDLE:   if (go) state_nx = CLEAR;
            CLEAR: begin
                state_nx = STREAM;
                k_nx     = '0;
            end
            STREAM: begin
                if (k == KLAST) state_nx = DRAIN;
                else            k_nx     = k + 1'b1;
            end
            DRAIN:  state_nx = DONE;
            DONE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output values for the current state, registered one cycle later
    always_comb begin
        start_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        v_d     = '0;
        a_d     = '0;
        unique case (state)
            CLEAR: begin
                start_d = 1'b1;
                busy_d  = 1'b1;
            end
            STREAM: begin
                busy_d = 1'b1;
                if (k < KN) v_d = vec[k[VW-1:0]];
                for (int i = 0; i < N; i++) begin
                    if (k >= KW'(i) && k <= KW'(i+N-1))
                        a_d[i*W +: W] =
                          mat[AW'(i*N) + AW'(k) - AW'(i)];
                end
            end
            DRAIN:  busy_d = 1'b1;
            DONE:   done_d = 1'b1;
            default: ;
        endcase
    end

    // Output flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pe_start <= 1'b0;
            pe_v     <= '0;
            pe_a     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            pe_start <= start_d;
            pe_v     <= v_d;
            pe_a     <= a_d;
            busy     <= busy_d;
            done     <= done_d;
            load_err <= wr_bad;
        end
    end

endmodule

// File: tb/tb_mxv_feeder.sv
// Randomized self-checking bench for mxv_feeder against a
// cycle-indexed reference of the stream schedule.
module tb_mxv_feeder;

    localparam int N = 4;
    localparam int W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             wr_en = 1'b0;
    logic             wr_sel = 1'b0;
    logic [3:0]       wr_addr = '0;
    logic [W-1:0]     wr_data = '0;
    logic             go = 1'b0;
    logic             pe_start;
    logic [W-1:0]     pe_v;
    logic [N*W-1:0]   pe_a;
    logic             busy;
    logic             done;
    logic             load_err;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] ma [N*N];
    logic [W-1:0] mv [N];

    mxv_feeder #(.N(N), .Word_Length(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .go       (go),
        .pe_start (pe_start),
        .pe_v     (pe_v),
        .pe_a     (pe_a),
        .busy     (busy),
        .done     (done),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    function automatic logic [43:0] obs();
        return {pe_start, pe_v, pe_a, busy, done, load_err};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N*N; i++) ma[i] = '0;
        for (int i = 0; i < N; i++)   mv[i] = '0;
    endtask

    // one write on the next edge; checks load_err after it
    task automatic write(input logic sel, input logic [3:0] addr,
                         input logic [W-1:0] data);
        logic ok;
        wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
        @(posedge clk); #1;
        wr_en = 1'b0;
        ok = sel ? (int'(addr) < N) : 1'b1;
        if (ok) begin
            if (sel) mv[addr] = data;
            else     ma[addr] = data;
        end
        checks++;
        if (load_err !== !ok) begin
            failures++;
            $display("FAIL write_err sel=%0d addr=%0d got=%0b exp=%0b",
                     sel, addr, load_err, !ok);
        end
    endtask

    // Go, then check 13 cycles. Cycle c counts edges after the go
    // edge: 1 clear, 2..2N steps, 2N+1 drain, 2N+2 done.
    task automatic run(input string nm, input int inj, input int rst_at,
                       input bit sw, input logic [W-1:0] swd);
        logic [W-1:0]   ev;
        logic [N*W-1:0] ea;
        logic           es, eb, ed, ee;
        logic [43:0]    e;
        int             kk, j;
        go = 1'b1;
        if (sw) begin
            wr_en = 1'b1; wr_sel = 1'b1; wr_addr = '0; wr_data = swd;
            mv[0] = swd;
        end
        @(posedge clk); #1;
        go = 1'b0; wr_en = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            @(posedge clk); #1;
            go = 1'b0; wr_en = 1'b0;
            es = 0; eb = 0; ed = 0; ee = 0; ev = '0; ea = '0;
            if (rst_at == 0 || c <= rst_at) begin
                if (c == 1) begin es = 1; eb = 1; end
                else if (c >= 2 && c <= 2*N) begin
                    eb = 1;
                    kk = c - 2;
                    if (kk < N) ev = mv[kk];
                    for (int i = 0; i < N; i++) begin
                        j = kk - i;
                        if (j >= 0 && j < N) ea[i*W +: W] = ma[i*N + j];
                    end
                end
                else if (c == 2*N+1) eb = 1;
                else if (c == 2*N+2) ed = 1;
                if (inj != 0 && c == inj + 1) ee = 1;
            end
            e = {es, ev, ea, eb, ed, ee};
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL %s cycle=%0d got=%h exp=%h", nm, c, obs(), e);
            end
            if (c == inj) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0;
                wr_data = 8'hFF; go = 1'b1;
            end
            if (rst_at != 0 && c == rst_at) begin
                #2 reset = 1'b0;
                #1;
                model_clear();
                checks++;
                if (obs() !== 44'h0) begin
                    failures++;
                    $display("FAIL %s async_reset got=%h exp=0", nm, obs());
                end
            end
            if (rst_at != 0 && c == rst_at + 2) reset = 1'b1;
        end
    endtask

    task automatic test_reset();
        model_clear();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs() !== 44'h0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=0", obs());
        end
        reset = 1'b1;
        write(1'b1, 4'd0, 8'h11);
    endtask

    task automatic test_basic();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                write(1'b0, 4'(r*N + c), 8'(r*N + c + 1));
        for (int i = 0; i < N; i++) write(1'b1, 4'(i), 8'(i + 1));
        run("basic", 0, 0, 1'b0, 8'h0);
        // fixed points from the worked example
        checks++;
        if (ma[3*N+3] !== 8'd16 || mv[3] !== 8'd4) begin
            failures++;
            $display("FAIL basic_model got=%0d/%0d exp=16/4",
                     ma[15], mv[3]);
        end
    endtask

    task automatic test_skew();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                write(1'b0, 4'(r*N + c), (r == c) ? 8'd1 : 8'd0);
        for (int i = 0; i < N; i++) write(1'b1, 4'(i), 8'(i + 5));
        run("skew", 0, 0, 1'b0, 8'h0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            for (int a = 0; a < N*N; a++)
                write(1'b0, 4'(a), 8'($urandom_range(0, 255)));
            for (int i = 0; i < N; i++)
                write(1'b1, 4'(i), 8'($urandom_range(0, 255)));
            run("random", 0, 0, 1'b0, 8'h0);
        end
    endtask

    task automatic test_busy_reject();
        run("busy_inj", 4, 0, 1'b0, 8'h0);
        run("busy_after", 0, 0, 1'b0, 8'h0);
    endtask

    task automatic test_bad_addr();
        write(1'b1, 4'd9, 8'h77);
        write(1'b1, 4'(N), 8'h55);
        run("bad_addr", 0, 0, 1'b0, 8'h0);
    endtask

    task automatic test_same_edge();
        run("same_edge", 0, 0, 1'b1, 8'h2A);
    endtask

    task automatic test_reset_mid();
        run("reset_mid", 0, 5, 1'b0, 8'h0);
        run("after_reset", 0, 0, 1'b0, 8'h0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_skew();
        test_random();
        test_busy_reject();
        test_bad_addr();
        test_same_edge();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
